sid_bus_read: RTL

Read-side register decoder and bus-hold model for the SID core. It is the read counterpart of the per-voice register write decoders. It answers CPU reads of the four readable SID registers: POTX, POTY, OSC3 and ENV3. It runs the 512-tick paddle measurement cycle that produces POTX/POTY. Reads of write-only addresses return the last value driven on the data bus, and that value decays to zero after a programmable idle time.

---
 rtl/sid_bus_read.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sid_bus_read.sv
// SID read-side decoder: answers POTX/POTY/OSC3/ENV3 reads, models the decaying
// open-bus value for write-only addresses, and runs the 512-tick paddle measurement.
module sid_bus_read #(
    parameter logic [4:0]  BASE_ADDR   = 5'd0,
    parameter int unsigned DECAY_TICKS = 2048
) (
    input  logic       clk,
    input  logic       iRst,
    input  logic       clkEn,
    input  logic       iWE,
    input  logic       iRE,
    input  logic [4:0] iAddr,
    input  logic [7:0] iData,
    input  logic [7:0] iOsc3,
    input  logic [7:0] iEnv3,
    input  logic       iPotX,
    input  logic       iPotY,
    output logic [7:0] oData,
    output logic       oDataValid,
    output logic       oPotDischarge
);

    localparam logic [15:0] DECAY_RELOAD = 16'(DECAY_TICKS);
    localparam logic [4:0]  OFS_POTX     = 5'h19;
    localparam logic [4:0]  OFS_POTY     = 5'h1A;
    localparam logic [4:0]  OFS_OSC3     = 5'h1B;
    localparam logic [4:0]  OFS_ENV3     = 5'h1C;
    localparam logic [8:0]  PH_LAST_DIS  = 9'd255;
    localparam logic [8:0]  PH_LAST      = 9'd511;

    typedef enum logic {
        ST_DISCHARGE = 1'b0,
        ST_CHARGE    = 1'b1
    } pot_state_t;

    // Read path
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [7:0]  bus_hold_q, bus_hold_d;
    logic [15:0] decay_q, decay_d;

    // Paddle path
    pot_state_t  state_q, state_d;
    logic [8:0]  ph_q, ph_d;
    logic        potx_meta_q, potx_meta_d;
    logic        potx_sync_q, potx_sync_d;
    logic        poty_meta_q, poty_meta_d;
    logic        poty_sync_q, poty_sync_d;
    logic [7:0]  capx_q, capx_d;
    logic [7:0]  capy_q, capy_d;
    logic        capturedx_q, capturedx_d;
    logic        capturedy_q, capturedy_d;
    logic [7:0]  potx_q, potx_d;
    logic [7:0]  poty_q, poty_d;

    logic [4:0]  offset;
    logic [7:0]  read_val;
    logic [7:0]  count;
    logic        hit_x;
    logic        hit_y;
    logic [7:0]  final_x;
    logic [7:0]  final_y;

    assign offset = iAddr - BASE_ADDR;

    always_comb begin
        read_val = bus_hold_q;
        case (offset)
            OFS_POTX: read_val = potx_q;
            OFS_POTY: read_val = poty_q;
            OFS_OSC3: read_val = iOsc3;
            OFS_ENV3: read_val = iEnv3;
            default:  read_val = bus_hold_q;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = iRE;
        if (iRE) begin
            data_d = read_val;
        end
    end

    // A write overrides a coincident read for the held value; the read itself
    // already returned the pre-write value through read_val.
    always_comb begin
        bus_hold_d = bus_hold_q;
        decay_d    = decay_q;
        if (iWE) begin
            bus_hold_d = iData;
            decay_d    = DECAY_RELOAD;
        end else if (iRE) begin
            bus_hold_d = read_val;
            decay_d    = DECAY_RELOAD;
        end else if (clkEn && (decay_q != 16'd0)) begin
            decay_d = decay_q - 16'd1;
            if (decay_q == 16'd1) begin
                bus_hold_d = 8'h00;
            end
        end
    end

    always_comb begin
        potx_meta_d = iPotX;
        potx_sync_d = potx_meta_q;
        poty_meta_d = iPotY;
        poty_sync_d = poty_meta_q;
    end

    assign count   = ph_q[7:0];
    assign hit_x   = potx_sync_q && !capturedx_q;
    assign hit_y   = poty_sync_q && !capturedy_q;
    assign final_x = hit_x ? count : (capturedx_q ? capx_q : 8'hFF);
    assign final_y = hit_y ? count : (capturedy_q ? capy_q : 8'hFF);

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        capx_d      = capx_q;
        capy_d      = capy_q;
        capturedx_d = capturedx_q;
        capturedy_d = capturedy_q;
        potx_d      = potx_q;
        poty_d      = poty_q;
        if (clkEn) begin
            ph_d = ph_q + 9'd1;
            case (state_q)
                ST_DISCHARGE: begin
                    if (ph_q == 9'd0) begin
                        capturedx_d = 1'b0;
                        capturedy_d = 1'b0;
                    end
                    if (ph_q == PH_LAST_DIS) begin
                        state_d = ST_CHARGE;
                    end
                end
                ST_CHARGE: begin
                    if (hit_x) begin
                        capx_d      = count;
                        capturedx_d = 1'b1;
                    end
                    if (hit_y) begin
                        capy_d      = count;
                        capturedy_d = 1'b1;
                    end
                    if (ph_q == PH_LAST) begin
                        capx_d  = final_x;
                        capy_d  = final_y;
                        potx_d  = final_x;
                        poty_d  = final_y;
                        state_d = ST_DISCHARGE;
                    end
                end
                default: state_d = ST_DISCHARGE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            bus_hold_q  <= 8'h00;
            decay_q     <= 16'd0;
            state_q     <= ST_DISCHARGE;
            ph_q        <= 9'd0;
            potx_meta_q <= 1'b0;
            potx_sync_q <= 1'b0;
            poty_meta_q <= 1'b0;
            poty_sync_q <= 1'b0;
            capx_q      <= 8'h00;
            capy_q      <= 8'h00;
            capturedx_q <= 1'b0;
            capturedy_q <= 1'b0;
            potx_q      <= 8'h00;
            poty_q      <= 8'h00;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            bus_hold_q  <= bus_hold_d;
            decay_q     <= decay_d;
            state_q     <= state_d;
            ph_q        <= ph_d;
            potx_meta_q <= potx_meta_d;
            potx_sync_q <= potx_sync_d;
            poty_meta_q <= poty_meta_d;
            poty_sync_q <= poty_sync_d;
            capx_q      <= capx_d;
            capy_q      <= capy_d;
            capturedx_q <= capturedx_d;
            capturedy_q <= capturedy_d;
            potx_q      <= potx_d;
            poty_q      <= poty_d;
        end
    end

    assign oData         = data_q;
    assign oDataValid    = valid_q;
    assign oPotDischarge = (state_q == ST_DISCHARGE);

endmodule
